// File: rtl/rc5_controller_pkg.sv
// Shared RC5 definitions: controller state encoding, table-size helpers and magic constants.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rc5_controller_pkg;

    // Controller states, in the order a key load and a block pass through them.
    typedef enum logic [2:0] {
        LOAD_KEY  = 3'd0,
        START_EXP = 3'd1,
        EXPAND    = 3'd2,
        READY     = 3'd3,
        START_CPH = 3'd4,
        CIPHER    = 3'd5
    } rc5_state_e;

    // RC5 magic constants for the supported word widths (P = Odd(e-2), Q = Odd(phi-1)).
    localparam logic [15:0] RC5_P16 = 16'hB7E1;
    localparam logic [15:0] RC5_Q16 = 16'h9E37;
    localparam logic [31:0] RC5_P32 = 32'hB7E1_5163;
    localparam logic [31:0] RC5_Q32 = 32'h9E37_79B9;
    localparam logic [63:0] RC5_P64 = 64'hB7E1_5162_8AED_2A6B;
    localparam logic [63:0] RC5_Q64 = 64'h9E37_79B9_7F4A_7C15;

    // Number of words in the expanded key table S for a given round count.
    function automatic int rc5_t_count(input int rounds);
        return 2 * (rounds + 1);
    endfunction

    // Word widths for which magic constants exist.
    function automatic bit rc5_w_supported(input int w);
        return (w == 16) || (w == 32) || (w == 64);
    endfunction

endpackage

// File: rtl/rc5_controller.sv
// RC5 sequencer: loads key bytes, kicks the key expander, then gates cipher block requests.
// Latency: key byte written same cycle as accepted; start pulses one cycle after the triggering event.
// Backpressure: oKeyReady only in LOAD_KEY, oBlkReady only in READY; other offers are ignored.
module rc5_controller
    import rc5_controller_pkg::*;
#(
    parameter  int W        = 32,
    parameter  int B        = 16,
    parameter  int R        = 12,
    localparam int T        = rc5_t_count(R),
    localparam int B_LENGTH = $clog2(B),
    localparam int T_LENGTH = $clog2(T)
) (
    input  logic                clk,
    input  logic                rst,
    // host key byte stream
    input  logic                iKeyValid,
    input  logic [7:0]          iKeyByte,
    output logic                oKeyReady,
    // key RAM write port
    output logic [B_LENGTH-1:0] oKey_address,
    output logic [7:0]          oKey_data,
    output logic                oKey_we,
    // key expander control
    output logic                oExpStart,
    input  logic                iExpDone,
    // S-table requesters and arbitrated port
    input  logic [T_LENGTH-1:0] iExp_S_address,
    input  logic                iExp_S_we,
    input  logic [T_LENGTH-1:0] iCph_S_address,
    output logic [T_LENGTH-1:0] oS_address,
    output logic                oS_we,
    // host block request
    input  logic                iBlkValid,
    input  logic                iDecrypt,
    output logic                oBlkReady,
    // cipher engine control
    output logic                oCphStart,
    output logic                oCphMode,
    input  logic                iCphDone,
    // rekey / status
    input  logic                iRekey,
    output logic                oKeyLoaded
);

    localparam logic [B_LENGTH-1:0] KEY_LAST = B_LENGTH'(B - 1);

    // Reject word widths that have no magic constants at elaboration time.
    if (!rc5_w_supported(W)) begin : g_bad_width
        $error("rc5_controller: unsupported word width W");
    end

    rc5_state_e          state_q, state_d;
    logic [B_LENGTH-1:0] cnt_q, cnt_d;
    logic                key_loaded_q, key_loaded_d;
    logic                cph_mode_q, cph_mode_d;

    // Next-state logic: key byte counting, expander/cipher sequencing, rekey and block latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_loaded_d = key_loaded_q;
        cph_mode_d   = cph_mode_q;
        case (state_q)
            LOAD_KEY: begin
                if (iKeyValid) begin
                    if (cnt_q == KEY_LAST) begin
                        cnt_d   = '0;
                        state_d = START_EXP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START_EXP: state_d = EXPAND;
            EXPAND: begin
                if (iExpDone) begin
                    state_d      = READY;
                    key_loaded_d = 1'b1;
                end
            end
            READY: begin
                // Rekey wins over a simultaneous block request.
                if (iRekey) begin
                    state_d      = LOAD_KEY;
                    key_loaded_d = 1'b0;
                    cnt_d        = '0;
                end else if (iBlkValid) begin
                    cph_mode_d = iDecrypt;
                    state_d    = START_CPH;
                end
            end
            START_CPH: state_d = CIPHER;
            CIPHER: begin
                if (iCphDone) begin
                    state_d = READY;
                end
            end
            default: state_d = LOAD_KEY;
        endcase
    end

    // State registers; reset returns to key loading from anywhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD_KEY;
            cnt_q        <= '0;
            key_loaded_q <= 1'b0;
            cph_mode_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_loaded_q <= key_loaded_d;
            cph_mode_q   <= cph_mode_d;
        end
    end

    // Output decode: handshakes, start pulses and the S-table port owner follow the state register.
    always_comb begin
        oKeyReady    = 1'b0;
        oKey_we      = 1'b0;
        oKey_data    = 8'h00;
        oKey_address = cnt_q;
        oExpStart    = 1'b0;
        oBlkReady    = 1'b0;
        oCphStart    = 1'b0;
        oS_address   = '0;
        oS_we        = 1'b0;
        case (state_q)
            LOAD_KEY: begin
                oKeyReady = 1'b1;
                oKey_we   = iKeyValid;
                oKey_data = iKeyValid ? iKeyByte : 8'h00;
            end
            START_EXP: begin
                oExpStart  = 1'b1;
                oS_address = iExp_S_address;
                oS_we      = iExp_S_we;
            end
            EXPAND: begin
                oS_address = iExp_S_address;
                oS_we      = iExp_S_we;
            end
            READY: oBlkReady = 1'b1;
            START_CPH: begin
                oCphStart  = 1'b1;
                oS_address = iCph_S_address;
            end
            CIPHER: oS_address = iCph_S_address;
            default: ;
        endcase
    end

    assign oKeyLoaded = key_loaded_q;
    assign oCphMode   = cph_mode_q;

endmodule

// File: tb/tb_rc5_controller.sv
// Directed bench for rc5_controller: key load, expansion, cipher blocks, rekey and reset.
// Latency: inputs applied 1 time unit after each rising edge, outputs checked 1 unit later.
// Backpressure: none modelled beyond the DUT handshakes.
module tb_rc5_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       iKeyValid;
    logic [7:0] iKeyByte;
    logic       oKeyReady;
    logic [3:0] oKey_address;
    logic [7:0] oKey_data;
    logic       oKey_we;
    logic       oExpStart;
    logic       iExpDone;
    logic [4:0] iExp_S_address;
    logic       iExp_S_we;
    logic [4:0] iCph_S_address;
    logic [4:0] oS_address;
    logic       oS_we;
    logic       iBlkValid;
    logic       iDecrypt;
    logic       oBlkReady;
    logic       oCphStart;
    logic       oCphMode;
    logic       iCphDone;
    logic       iRekey;
    logic       oKeyLoaded;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rc5_controller #(.W(32), .B(16), .R(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .iKeyValid      (iKeyValid),
        .iKeyByte       (iKeyByte),
        .oKeyReady      (oKeyReady),
        .oKey_address   (oKey_address),
        .oKey_data      (oKey_data),
        .oKey_we        (oKey_we),
        .oExpStart      (oExpStart),
        .iExpDone       (iExpDone),
        .iExp_S_address (iExp_S_address),
        .iExp_S_we      (iExp_S_we),
        .iCph_S_address (iCph_S_address),
        .oS_address     (oS_address),
        .oS_we          (oS_we),
        .iBlkValid      (iBlkValid),
        .iDecrypt       (iDecrypt),
        .oBlkReady      (oBlkReady),
        .oCphStart      (oCphStart),
        .oCphMode       (oCphMode),
        .iCphDone       (iCphDone),
        .iRekey         (iRekey),
        .oKeyLoaded     (oKeyLoaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed 16 back-to-back key bytes starting at value base, checking the RAM write port each cycle.
    task automatic load_key(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            iKeyValid = 1'b1;
            iKeyByte  = base + 8'(i);
            #1;
            chk($sformatf("key_we[%0d]", i), 32'(oKey_we), 32'd1);
            chk($sformatf("key_addr[%0d]", i), 32'(oKey_address), 32'(i));
            chk($sformatf("key_data[%0d]", i), 32'(oKey_data), 32'(base + 8'(i)));
            chk($sformatf("exp_start_low[%0d]", i), 32'(oExpStart), 32'd0);
            tick();
        end
        iKeyValid = 1'b0;
        iKeyByte  = 8'h00;
    endtask

    initial begin
        rst            = 1'b1;
        iKeyValid      = 1'b0;
        iKeyByte       = 8'h00;
        iExpDone       = 1'b0;
        iExp_S_address = 5'd0;
        iExp_S_we      = 1'b0;
        iCph_S_address = 5'd0;
        iBlkValid      = 1'b0;
        iDecrypt       = 1'b0;
        iCphDone       = 1'b0;
        iRekey         = 1'b0;
        tick();
        tick();
        #1;
        // Reset state: only oKeyReady is high.
        chk("rst_key_ready", 32'(oKeyReady), 32'd1);
        chk("rst_key_we", 32'(oKey_we), 32'd0);
        chk("rst_exp_start", 32'(oExpStart), 32'd0);
        chk("rst_blk_ready", 32'(oBlkReady), 32'd0);
        chk("rst_cph_start", 32'(oCphStart), 32'd0);
        chk("rst_cph_mode", 32'(oCphMode), 32'd0);
        chk("rst_key_loaded", 32'(oKeyLoaded), 32'd0);
        chk("rst_s_addr", 32'(oS_address), 32'd0);
        chk("rst_s_we", 32'(oS_we), 32'd0);
        chk("rst_key_addr", 32'(oKey_address), 32'd0);
        rst = 1'b0;
        tick();

        // Key load with iExpDone already high; it must be ignored until EXPAND.
        iExpDone = 1'b1;
        load_key(8'h00);
        // Now in START_EXP.
        iKeyValid      = 1'b1;
        iExp_S_address = 5'd3;
        iExp_S_we      = 1'b1;
        #1;
        chk("exp_start_pulse", 32'(oExpStart), 32'd1);
        chk("startexp_key_ready", 32'(oKeyReady), 32'd0);
        chk("startexp_key_we", 32'(oKey_we), 32'd0);
        chk("startexp_s_addr", 32'(oS_address), 32'd3);
        chk("startexp_s_we", 32'(oS_we), 32'd1);
        chk("startexp_loaded", 32'(oKeyLoaded), 32'd0);
        tick();
        // Now in EXPAND.
        iKeyValid      = 1'b0;
        iExpDone       = 1'b0;
        iExp_S_address = 5'd5;
        iExp_S_we      = 1'b1;
        #1;
        chk("expand_exp_start_low", 32'(oExpStart), 32'd0);
        chk("expand_loaded", 32'(oKeyLoaded), 32'd0);
        chk("expand_s_addr", 32'(oS_address), 32'd5);
        chk("expand_s_we", 32'(oS_we), 32'd1);
        for (int i = 0; i < 50; i++) tick();
        chk("expand50_loaded", 32'(oKeyLoaded), 32'd0);
        chk("expand50_blk_ready", 32'(oBlkReady), 32'd0);
        iExpDone = 1'b1;
        tick();
        // Now in READY; expander requests must no longer reach the S port.
        iExpDone = 1'b0;
        #1;
        chk("ready_loaded", 32'(oKeyLoaded), 32'd1);
        chk("ready_blk_ready", 32'(oBlkReady), 32'd1);
        chk("ready_s_addr", 32'(oS_address), 32'd0);
        chk("ready_s_we", 32'(oS_we), 32'd0);
        iExp_S_address = 5'd0;
        iExp_S_we      = 1'b0;

        // Decrypt block.
        iBlkValid = 1'b1;
        iDecrypt  = 1'b1;
        tick();
        iBlkValid = 1'b0;
        iDecrypt  = 1'b0;
        #1;
        chk("dec_cph_start", 32'(oCphStart), 32'd1);
        chk("dec_cph_mode", 32'(oCphMode), 32'd1);
        chk("dec_blk_ready_low", 32'(oBlkReady), 32'd0);
        tick();
        // Now in CIPHER; rekey and expander writes must be ignored here.
        iCph_S_address = 5'd9;
        iExp_S_we      = 1'b1;
        iRekey         = 1'b1;
        #1;
        chk("cph_start_low", 32'(oCphStart), 32'd0);
        chk("cipher_s_addr", 32'(oS_address), 32'd9);
        chk("cipher_s_we", 32'(oS_we), 32'd0);
        tick();
        iRekey    = 1'b0;
        iExp_S_we = 1'b0;
        #1;
        chk("cipher_rekey_ignored_ready", 32'(oKeyReady), 32'd0);
        chk("cipher_rekey_ignored_loaded", 32'(oKeyLoaded), 32'd1);
        for (int i = 0; i < 25; i++) tick();
        chk("cipher_busy_blk_ready", 32'(oBlkReady), 32'd0);
        iCphDone = 1'b1;
        tick();
        iCphDone = 1'b0;
        #1;
        chk("dec_done_blk_ready", 32'(oBlkReady), 32'd1);
        chk("dec_mode_held", 32'(oCphMode), 32'd1);

        // Encrypt block; iDecrypt moving during CIPHER must not disturb the latched mode.
        iBlkValid = 1'b1;
        iDecrypt  = 1'b0;
        tick();
        iBlkValid = 1'b0;
        #1;
        chk("enc_cph_start", 32'(oCphStart), 32'd1);
        chk("enc_cph_mode", 32'(oCphMode), 32'd0);
        tick();
        iDecrypt = 1'b1;
        tick();
        iCphDone = 1'b1;
        tick();
        iCphDone = 1'b0;
        iDecrypt = 1'b0;
        #1;
        chk("enc_mode_held", 32'(oCphMode), 32'd0);
        chk("enc_done_blk_ready", 32'(oBlkReady), 32'd1);

        // Rekey and block request together: rekey wins.
        iRekey    = 1'b1;
        iBlkValid = 1'b1;
        iDecrypt  = 1'b1;
        tick();
        iRekey    = 1'b0;
        iBlkValid = 1'b0;
        iDecrypt  = 1'b0;
        #1;
        chk("rekey_key_ready", 32'(oKeyReady), 32'd1);
        chk("rekey_cph_start", 32'(oCphStart), 32'd0);
        chk("rekey_loaded", 32'(oKeyLoaded), 32'd0);
        chk("rekey_blk_ready", 32'(oBlkReady), 32'd0);
        chk("rekey_key_addr", 32'(oKey_address), 32'd0);
        tick();
        chk("rekey_no_late_start", 32'(oCphStart), 32'd0);

        // Second key load, expansion, then reset in the middle of a cipher pass.
        load_key(8'hA0);
        tick();
        iExpDone = 1'b1;
        tick();
        iExpDone  = 1'b0;
        iBlkValid = 1'b1;
        iDecrypt  = 1'b1;
        tick();
        iBlkValid = 1'b0;
        iDecrypt  = 1'b0;
        tick();
        tick();
        #1;
        chk("pre_rst_loaded", 32'(oKeyLoaded), 32'd1);
        chk("pre_rst_mode", 32'(oCphMode), 32'd1);
        rst = 1'b1;
        #1;
        chk("midcph_rst_key_ready", 32'(oKeyReady), 32'd1);
        chk("midcph_rst_loaded", 32'(oKeyLoaded), 32'd0);
        chk("midcph_rst_blk_ready", 32'(oBlkReady), 32'd0);
        chk("midcph_rst_mode", 32'(oCphMode), 32'd0);
        chk("midcph_rst_cph_start", 32'(oCphStart), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a key load must clear the byte counter.
        for (int i = 0; i < 3; i++) begin
            iKeyValid = 1'b1;
            iKeyByte  = 8'h55;
            tick();
        end
        iKeyValid = 1'b0;
        #1;
        chk("midload_addr", 32'(oKey_address), 32'd3);
        rst = 1'b1;
        #1;
        chk("midload_rst_addr", 32'(oKey_address), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        iKeyValid = 1'b1;
        iKeyByte  = 8'h77;
        #1;
        chk("postrst_addr", 32'(oKey_address), 32'd0);
        chk("postrst_data", 32'(oKey_data), 32'h77);
        iKeyValid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rc5_controller.md
RC5_CONTROLLER -- requirements
Module: rc5_controller

Interface
REQ-001 SHALL have parameter W, default 32: cipher word width in bits.
REQ-002 SHALL have parameter B, default 16: secret-key length in bytes.
REQ-003 SHALL have parameter R, default 12: round count; T = 2*(R+1), B_LENGTH = $clog2(B), T_LENGTH = $clog2(T).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port iKeyValid  input  1  host key byte offered.
REQ-007 SHALL have port iKeyByte  input  8  host key byte.
REQ-008 SHALL have port oKeyReady  output  1  controller accepts key byte.
REQ-009 SHALL have ports oKey_address  output  B_LENGTH, oKey_data  output  8, oKey_we  output  1: key RAM write port.
REQ-010 SHALL have ports oExpStart  output  1 (expander start pulse) and iExpDone  input  1 (expander done level).
REQ-011 SHALL have ports iExp_S_address  input  T_LENGTH, iExp_S_we  input  1, iCph_S_address  input  T_LENGTH: S-table requesters.
REQ-012 SHALL have ports oS_address  output  T_LENGTH, oS_we  output  1: arbitrated S-table port.
REQ-013 SHALL have ports iBlkValid  input  1, iDecrypt  input  1, oBlkReady  output  1: host block-request handshake.
REQ-014 SHALL have ports oCphStart  output  1, oCphMode  output  1 (1 = decrypt), iCphDone  input  1: cipher engine control.
REQ-015 SHALL have ports iRekey  input  1 (restart key load) and oKeyLoaded  output  1 (expanded key valid).

Function
REQ-016 FSM states SHALL be LOAD_KEY, START_EXP, EXPAND, READY, START_CPH, CIPHER; reset state LOAD_KEY.
REQ-017 LOAD_KEY: oKeyReady=1; each cycle with iKeyValid=1 SHALL assert oKey_we=1 combinationally, drive oKey_data=iKeyByte, oKey_address=byte counter, increment counter.
REQ-018 Acceptance of byte at counter B-1 SHALL move to START_EXP next cycle and wrap counter to 0.
REQ-019 START_EXP SHALL last exactly one cycle with oExpStart=1, then EXPAND.
REQ-020 EXPAND SHALL wait for iExpDone=1, then enter READY and set oKeyLoaded=1; iExpDone outside EXPAND SHALL be ignored.
REQ-021 READY: oBlkReady=1; iBlkValid=1 SHALL latch iDecrypt into oCphMode and move to START_CPH.
REQ-022 START_CPH SHALL last one cycle with oCphStart=1, then CIPHER; CIPHER SHALL return to READY on iCphDone=1 (ignored elsewhere).
REQ-023 iRekey=1 in READY SHALL take priority over iBlkValid, clear oKeyLoaded, zero counter, enter LOAD_KEY; iRekey SHALL be ignored in all other states.
REQ-024 S-port mux: START_EXP/EXPAND -> oS_address=iExp_S_address, oS_we=iExp_S_we; START_CPH/CIPHER -> oS_address=iCph_S_address, oS_we=0; other states -> 0, 0.
REQ-025 oKeyReady, oBlkReady, oKey_we, oS_we SHALL never be 1 outside the states stated above.
REQ-026 oCphMode SHALL hold its latched value until the next accepted block.

Reset
REQ-027 rst=1 SHALL immediately force LOAD_KEY, counter=0, oKeyLoaded=0, oCphMode=0, oExpStart=0, oCphStart=0, including mid-expansion or mid-cipher.
REQ-028 After reset, all outputs SHALL be 0 except oKeyReady=1.

Structure
REQ-029 State encoding and T/length derivation SHALL live in a shared rc5 package alongside QW-style constants.
REQ-030 Single module; byte counter MAY use the team's FFD_POSEDGE_SYNCRONOUS_RESET-style register only if an asynchronous-reset variant is used; no other sub-module.

Verification
REQ-031 Reset, feed 16 bytes 0x00..0x0F back-to-back -> oKey_we 16 cycles, addresses 0..15, oExpStart one cycle after byte 15.
REQ-032 Hold iExpDone=1 before START_EXP; raise in EXPAND after 50 cycles -> READY, oKeyLoaded=1 only then.
REQ-033 READY, iBlkValid=1, iDecrypt=1 -> oCphStart pulse next cycle, oCphMode=1; iCphDone after 26 cycles -> oBlkReady=1.
REQ-034 READY, iRekey=1 and iBlkValid=1 same cycle -> LOAD_KEY, no oCphStart, oKeyLoaded=0.
REQ-035 In EXPAND, iExp_S_address=5, iExp_S_we=1 -> oS_address=5, oS_we=1; in CIPHER iCph_S_address=9 -> oS_address=9, oS_we=0.
REQ-036 Assert rst during CIPHER -> same cycle LOAD_KEY, oKeyLoaded=0, oBlkReady=0.
